dma_txn_arbiter: RTL and testbench

Shares the single AXI command issue port between the DMA read streamer and write streamer. Sits between the streamers and the AXI master, enabled while the DMA controller is in its active state. It arbitrates requests, registers and issues one command at a time over a valid/ready handshake, and tracks outstanding transactions per direction. It drives the aggregated pending-transaction indication back to the DMA controller and drains cleanly on abort.

---
 rtl/dma_arb_pkg.sv | 24 ++
 rtl/dma_ot_counter.sv | 33 +++
 rtl/dma_txn_arbiter.sv | 128 ++++++++++++
 tb/tb_dma_txn_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and default sizes for the DMA read/write command arbiter.
// dma_cmd_t fixes the command field widths to the DMA_* defaults below.
package dma_arb_pkg;

  localparam int DMA_ADDR_W = 32;
  localparam int DMA_LEN_W  = 8;
  localparam int DMA_ID_W   = 3;
  localparam int DMA_MAX_OT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } arb_st_t;

  typedef struct packed {
    logic                  write;
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_LEN_W-1:0]  len;
    logic [DMA_ID_W-1:0]   id;
  } dma_cmd_t;

endpackage

// File: rtl/dma_ot_counter.sv
// Outstanding-transaction counter: saturating up/down with a sticky underflow flag.
module dma_ot_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err
);

  localparam logic [W-1:0] CMAX = W'(MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      // issue and completion in the same cycle cancel out
      case ({inc, dec})
        2'b10: if (cnt < CMAX) cnt <= cnt + 1'b1;
        2'b01: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dma_txn_arbiter.sv
// Shares the AXI command port between the DMA read and write streamers.
// Define DMA_ARB_RR_EN for round-robin; otherwise reads have fixed priority.
module dma_txn_arbiter
  import dma_arb_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int LEN_W  = DMA_LEN_W,
  parameter int ID_W   = DMA_ID_W,
  parameter int MAX_OT = DMA_MAX_OT,
  parameter int OT_W   = $clog2(MAX_OT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_active_i,
  input  logic              abort_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [LEN_W-1:0]  rd_len_i,
  input  logic [ID_W-1:0]   rd_desc_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [LEN_W-1:0]  wr_len_i,
  input  logic [ID_W-1:0]   wr_desc_i,
  output logic              rd_gnt_o,
  output logic              wr_gnt_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              cmd_write_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [LEN_W-1:0]  cmd_len_o,
  output logic [ID_W-1:0]   cmd_id_o,
  input  logic              rd_cpl_i,
  input  logic              wr_cpl_i,
  output logic [OT_W-1:0]   rd_ot_o,
  output logic [OT_W-1:0]   wr_ot_o,
  output logic              axi_pend_txn_o,
  output logic              cpl_err_o
);

  localparam logic [OT_W-1:0] OT_MAX = OT_W'(MAX_OT);

  arb_st_t         state;
  dma_cmd_t        cmd_q, cmd_d;
  logic [OT_W-1:0] rd_ot, wr_ot;
  logic            rd_err, wr_err;
  logic            go, rd_elig, wr_elig, pick_wr, sel, hs;

  assign go      = dma_active_i & ~abort_i;
  assign rd_elig = rd_req_i & (rd_ot < OT_MAX);
  assign wr_elig = wr_req_i & (wr_ot < OT_MAX);

`ifdef DMA_ARB_RR_EN
  logic ptr_wr;
  assign pick_wr = wr_elig & (~rd_elig | ptr_wr);

  // pointer favours the direction that did not issue last
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr_wr <= 1'b0;
    else if (hs) ptr_wr <= ~cmd_q.write;
  end
`else
  assign pick_wr = wr_elig & ~rd_elig;
`endif

  assign sel      = (state == ARB) & go & (rd_elig | wr_elig);
  assign rd_gnt_o = sel & ~pick_wr;
  assign wr_gnt_o = sel & pick_wr;
  assign hs       = (state == ISSUE) & cmd_ready_i;

  always_comb begin
    cmd_d       = '0;
    cmd_d.write = pick_wr;
    cmd_d.addr  = pick_wr ? wr_addr_i : rd_addr_i;
    cmd_d.len   = pick_wr ? wr_len_i  : rd_len_i;
    cmd_d.id    = pick_wr ? wr_desc_i : rd_desc_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cmd_q <= '0;
    end else begin
      case (state)
        IDLE: if (go) state <= ARB;
        ARB: begin
          if (!go) state <= DRAIN;
          else if (sel) begin
            state <= ISSUE;
            cmd_q <= cmd_d;
          end
        end
        // a presented command is never withdrawn; abort waits for its handshake
        ISSUE: if (cmd_ready_i) state <= go ? ARB : DRAIN;
        DRAIN: if (rd_ot == '0 && wr_ot == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dma_ot_counter #(.MAX(MAX_OT), .W(OT_W)) u_rd_ot (
    .clk (clk),
    .rst (rst),
    .inc (hs & ~cmd_q.write),
    .dec (rd_cpl_i),
    .cnt (rd_ot),
    .err (rd_err)
  );

  dma_ot_counter #(.MAX(MAX_OT), .W(OT_W)) u_wr_ot (
    .clk (clk),
    .rst (rst),
    .inc (hs & cmd_q.write),
    .dec (wr_cpl_i),
    .cnt (wr_ot),
    .err (wr_err)
  );

  assign cmd_valid_o    = (state == ISSUE);
  assign cmd_write_o    = cmd_q.write;
  assign cmd_addr_o     = cmd_q.addr;
  assign cmd_len_o      = cmd_q.len;
  assign cmd_id_o       = cmd_q.id;
  assign rd_ot_o        = rd_ot;
  assign wr_ot_o        = wr_ot;
  assign axi_pend_txn_o = (state == ISSUE) | (rd_ot != '0) | (wr_ot != '0);
  assign cpl_err_o      = rd_err | wr_err;

endmodule

// File: tb/tb_dma_txn_arbiter.sv
// Bench for dma_txn_arbiter: arbitration vector table, command scoreboard,
// and hand-written contention, saturation, backpressure, abort and reset sequences.
module tb_dma_txn_arbiter;
  import dma_arb_pkg::*;

`ifdef DMA_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_active_i, abort_i;
  logic        rd_req_i, wr_req_i;
  logic [31:0] rd_addr_i, wr_addr_i;
  logic [7:0]  rd_len_i, wr_len_i;
  logic [2:0]  rd_desc_i, wr_desc_i;
  logic        rd_gnt_o, wr_gnt_o;
  logic        cmd_valid_o, cmd_ready_i, cmd_write_o;
  logic [31:0] cmd_addr_o;
  logic [7:0]  cmd_len_o;
  logic [2:0]  cmd_id_o;
  logic        rd_cpl_i, wr_cpl_i;
  logic [2:0]  rd_ot_o, wr_ot_o;
  logic        axi_pend_txn_o, cpl_err_o;

  always #5 clk = ~clk;

  dma_txn_arbiter dut (
    .clk(clk), .rst(rst), .dma_active_i(dma_active_i), .abort_i(abort_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_len_i(rd_len_i), .rd_desc_i(rd_desc_i),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_len_i(wr_len_i), .wr_desc_i(wr_desc_i),
    .rd_gnt_o(rd_gnt_o), .wr_gnt_o(wr_gnt_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_write_o(cmd_write_o),
    .cmd_addr_o(cmd_addr_o), .cmd_len_o(cmd_len_o), .cmd_id_o(cmd_id_o),
    .rd_cpl_i(rd_cpl_i), .wr_cpl_i(wr_cpl_i), .rd_ot_o(rd_ot_o), .wr_ot_o(wr_ot_o),
    .axi_pend_txn_o(axi_pend_txn_o), .cpl_err_o(cpl_err_o)
  );

  typedef struct {
    logic       rd, wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  desc;
    logic [1:0]  gnt;   // {wr, rd}
  } vec_t;

  vec_t     vecs [9];
  dma_cmd_t exp_q[$];
  int       n_cmp = 0;
  int       n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic dma_cmd_t mk(input logic w, input logic [31:0] a, input logic [7:0] l,
                                  input logic [2:0] d);
    dma_cmd_t c;
    c.write = w; c.addr = a; c.len = l; c.id = d;
    return c;
  endfunction

  function automatic dma_cmd_t exp_rd();
    return mk(1'b0, rd_addr_i, rd_len_i, rd_desc_i);
  endfunction

  function automatic dma_cmd_t exp_wr();
    return mk(1'b1, wr_addr_i, wr_len_i, wr_desc_i);
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drain_cpl(input int nr, input int nw);
    for (int k = 0; k < ((nr > nw) ? nr : nw); k++) begin
      rd_cpl_i = (k < nr);
      wr_cpl_i = (k < nw);
      cyc();
    end
    rd_cpl_i = 1'b0;
    wr_cpl_i = 1'b0;
  endtask

  // scoreboard: every accepted command must match the oldest expected one
  always @(negedge clk) begin
    dma_cmd_t e;
    if (!rst && cmd_valid_o && cmd_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_cmd: got %0h expected none",
                 {cmd_write_o, cmd_addr_o, cmd_len_o, cmd_id_o});
      end else begin
        e = exp_q.pop_front();
        chk("cmd", {cmd_write_o, cmd_addr_o, cmd_len_o, cmd_id_o}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int order[$];
    int ngnt;

    vecs[0] = '{1'b1, 1'b0, 32'h1000, 8'd7,   3'd2, 2'b01};
    vecs[1] = '{1'b0, 1'b1, 32'h2000, 8'd3,   3'd5, 2'b10};
    vecs[2] = '{1'b1, 1'b1, 32'h3000, 8'd15,  3'd1, 2'b01};
    vecs[3] = '{1'b1, 1'b1, 32'h4000, 8'd0,   3'd6, RR ? 2'b10 : 2'b01};
    vecs[4] = '{1'b0, 1'b0, 32'h5000, 8'd1,   3'd1, 2'b00};
    vecs[5] = '{1'b1, 1'b1, 32'h6000, 8'd255, 3'd7, 2'b01};
    vecs[6] = '{1'b1, 1'b1, 32'h7000, 8'd9,   3'd3, RR ? 2'b10 : 2'b01};
    vecs[7] = '{1'b1, 1'b0, 32'h8000, 8'd4,   3'd4, 2'b01};
    vecs[8] = '{1'b0, 1'b1, 32'h9000, 8'd2,   3'd0, 2'b10};

    rst = 1'b1; dma_active_i = 1'b1; abort_i = 1'b0;
    rd_req_i = 1'b1; wr_req_i = 1'b1; cmd_ready_i = 1'b1;
    rd_addr_i = 32'h55; wr_addr_i = 32'h66; rd_len_i = 8'd1; wr_len_i = 8'd1;
    rd_desc_i = 3'd1; wr_desc_i = 3'd1; rd_cpl_i = 1'b0; wr_cpl_i = 1'b0;

    smp();
    chk("rst_valid", cmd_valid_o, 0);
    chk("rst_rd_gnt", rd_gnt_o, 0);
    chk("rst_wr_gnt", wr_gnt_o, 0);
    chk("rst_rd_ot", rd_ot_o, 0);
    chk("rst_wr_ot", wr_ot_o, 0);
    chk("rst_pend", axi_pend_txn_o, 0);
    chk("rst_err", cpl_err_o, 0);
    chk("rst_addr", cmd_addr_o, 0);

    cyc(); rst = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0;
    smp(); chk("idle_no_gnt", rd_gnt_o | wr_gnt_o, 0);
    cyc();

    for (int i = 0; i < 9; i++) begin
      rd_req_i  = vecs[i].rd;  wr_req_i  = vecs[i].wr;
      rd_addr_i = vecs[i].addr; rd_len_i = vecs[i].len; rd_desc_i = vecs[i].desc;
      wr_addr_i = vecs[i].addr ^ 32'h8000_0000; wr_len_i = ~vecs[i].len; wr_desc_i = ~vecs[i].desc;
      smp();
      chk($sformatf("v%0d_rd_gnt", i), rd_gnt_o, vecs[i].gnt[0]);
      chk($sformatf("v%0d_wr_gnt", i), wr_gnt_o, vecs[i].gnt[1]);
      if (vecs[i].gnt != 2'b00) exp_q.push_back(vecs[i].gnt[1] ? exp_wr() : exp_rd());
      cyc(); rd_req_i = 1'b0; wr_req_i = 1'b0;
      if (vecs[i].gnt != 2'b00) begin
        smp();
        chk($sformatf("v%0d_valid", i), cmd_valid_o, 1);
        chk($sformatf("v%0d_pend", i), axi_pend_txn_o, 1);
        cyc();
        smp();
        chk($sformatf("v%0d_rd_ot", i), rd_ot_o, vecs[i].gnt[0]);
        chk($sformatf("v%0d_wr_ot", i), wr_ot_o, vecs[i].gnt[1]);
        cyc(); rd_cpl_i = vecs[i].gnt[0]; wr_cpl_i = vecs[i].gnt[1];
        cyc(); rd_cpl_i = 1'b0; wr_cpl_i = 1'b0;
        smp();
        chk($sformatf("v%0d_ot_done", i), {rd_ot_o, wr_ot_o}, 0);
        chk($sformatf("v%0d_pend_done", i), axi_pend_txn_o, 0);
        cyc();
      end else begin
        smp(); chk($sformatf("v%0d_no_valid", i), cmd_valid_o, 0);
        cyc();
      end
    end

    // contention: both streamers request continuously
    rd_addr_i = 32'hA000; rd_len_i = 8'd1; rd_desc_i = 3'd1;
    wr_addr_i = 32'hB000; wr_len_i = 8'd2; wr_desc_i = 3'd6;
    rd_req_i = 1'b1; wr_req_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      smp();
      if (rd_gnt_o) begin exp_q.push_back(exp_rd()); order.push_back(0); end
      if (wr_gnt_o) begin exp_q.push_back(exp_wr()); order.push_back(1); end
      cyc();
    end
    rd_req_i = 1'b0; wr_req_i = 1'b0;
    chk("cont_n", order.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("cont_order%0d", k), (k < order.size()) ? order[k] : 9, RR ? (k % 2) : 0);
    smp();
    chk("cont_rd_ot", rd_ot_o, RR ? 2 : 4);
    chk("cont_wr_ot", wr_ot_o, RR ? 2 : 0);
    cyc();
    drain_cpl(RR ? 2 : 4, RR ? 2 : 0);
    smp(); chk("cont_pend", axi_pend_txn_o, 0);
    cyc();

    // saturation: fifth read blocked, write still served, read resumes after a completion
    rd_addr_i = 32'hC000; rd_len_i = 8'd3; rd_desc_i = 3'd3;
    wr_addr_i = 32'hD000; wr_len_i = 8'd5; wr_desc_i = 3'd5;
    rd_req_i = 1'b1; ngnt = 0;
    for (int k = 0; k < 8; k++) begin
      smp();
      if (rd_gnt_o) begin exp_q.push_back(exp_rd()); ngnt++; end
      cyc();
    end
    chk("sat_rd_n", ngnt, 4);
    smp();
    chk("sat_rd_ot", rd_ot_o, 4);
    chk("sat_rd_blocked", rd_gnt_o, 0);
    cyc(); wr_req_i = 1'b1;
    smp();
    chk("sat_wr_gnt", wr_gnt_o, 1);
    chk("sat_rd_gnt0", rd_gnt_o, 0);
    exp_q.push_back(exp_wr());
    cyc(); wr_req_i = 1'b0;
    smp(); chk("sat_wr_valid", cmd_valid_o, 1);
    cyc();
    smp();
    chk("sat_still_blocked", rd_gnt_o, 0);
    chk("sat_wr_ot", wr_ot_o, 1);
    cyc(); rd_cpl_i = 1'b1;
    smp(); chk("sat_cpl_cycle", rd_gnt_o, 0);
    cyc(); rd_cpl_i = 1'b0;
    smp();
    chk("sat_rd_ot_dec", rd_ot_o, 3);
    chk("sat_rd_regnt", rd_gnt_o, 1);
    exp_q.push_back(exp_rd());
    cyc(); rd_req_i = 1'b0;
    cyc();
    smp(); chk("sat_rd_ot_full", rd_ot_o, 4);
    cyc();
    drain_cpl(4, 1);
    smp(); chk("sat_pend", axi_pend_txn_o, 0);
    cyc();

    // backpressure: command held for 5 cycles, no further grants
    rd_addr_i = 32'hE000; rd_len_i = 8'h20; rd_desc_i = 3'd7;
    cmd_ready_i = 1'b0; rd_req_i = 1'b1;
    smp(); chk("bp_gnt", rd_gnt_o, 1);
    exp_q.push_back(exp_rd());
    cyc(); rd_req_i = 1'b0; wr_req_i = 1'b1;
    wr_addr_i = 32'hF000; wr_len_i = 8'h11; wr_desc_i = 3'd2;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk($sformatf("bp_valid%0d", k), cmd_valid_o, 1);
      chk($sformatf("bp_hold%0d", k), {cmd_write_o, cmd_addr_o, cmd_len_o, cmd_id_o},
          mk(1'b0, 32'hE000, 8'h20, 3'd7));
      chk($sformatf("bp_nognt%0d", k), rd_gnt_o | wr_gnt_o, 0);
      cyc();
    end
    cmd_ready_i = 1'b1;
    smp(); chk("bp_valid6", cmd_valid_o, 1);
    cyc();
    smp(); chk("bp_wr_gnt", wr_gnt_o, 1);
    exp_q.push_back(exp_wr());
    cyc(); wr_req_i = 1'b0;
    cyc();
    drain_cpl(1, 1);
    smp(); chk("bp_pend", axi_pend_txn_o, 0);
    cyc();

    // abort with two reads outstanding and a third in ISSUE
    rd_addr_i = 32'h100; rd_len_i = 8'd2; rd_desc_i = 3'd1;
    rd_req_i = 1'b1; ngnt = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      if (rd_gnt_o) begin exp_q.push_back(exp_rd()); ngnt++; end
      cyc();
    end
    chk("ab_pre_n", ngnt, 2);
    smp(); chk("ab_gnt3", rd_gnt_o, 1);
    exp_q.push_back(exp_rd());
    cyc(); rd_req_i = 1'b0; cmd_ready_i = 1'b0; abort_i = 1'b1;
    smp(); chk("ab_hold", cmd_valid_o, 1);
    cyc(); cmd_ready_i = 1'b1;
    smp(); chk("ab_valid", cmd_valid_o, 1);
    cyc(); rd_req_i = 1'b1; wr_req_i = 1'b1;
    smp();
    chk("ab_rd_ot", rd_ot_o, 3);
    chk("ab_no_gnt", {rd_gnt_o, wr_gnt_o}, 0);
    chk("ab_no_valid", cmd_valid_o, 0);
    chk("ab_pend", axi_pend_txn_o, 1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      rd_cpl_i = 1'b1;
      smp(); chk($sformatf("ab_drain_nognt%0d", k), {rd_gnt_o, wr_gnt_o}, 0);
      cyc();
    end
    rd_cpl_i = 1'b0;
    smp();
    chk("ab_pend_clear", axi_pend_txn_o, 0);
    chk("ab_rd_ot0", rd_ot_o, 0);
    cyc(); wr_req_i = 1'b0; abort_i = 1'b0;
    smp(); chk("ab_idle_nognt", rd_gnt_o, 0);
    cyc();
    smp(); chk("ab_resume", rd_gnt_o, 1);
    exp_q.push_back(exp_rd());
    cyc(); rd_req_i = 1'b0;
    cyc();
    drain_cpl(1, 0);

    // completion coinciding with a read handshake
    rd_addr_i = 32'h200; rd_len_i = 8'd1; rd_desc_i = 3'd2; rd_req_i = 1'b1;
    smp(); chk("co_gnt1", rd_gnt_o, 1);
    exp_q.push_back(exp_rd());
    cyc(); rd_req_i = 1'b0;
    cyc(); rd_req_i = 1'b1;
    smp(); chk("co_gnt2", rd_gnt_o, 1);
    exp_q.push_back(exp_rd());
    cyc(); rd_req_i = 1'b0; rd_cpl_i = 1'b1;
    cyc(); rd_cpl_i = 1'b0;
    smp();
    chk("co_rd_ot", rd_ot_o, 1);
    chk("co_err", cpl_err_o, 0);
    cyc();
    drain_cpl(1, 0);
    smp(); chk("co_rd_ot0", rd_ot_o, 0);

    // completion with nothing outstanding
    cyc(); rd_cpl_i = 1'b1;
    cyc(); rd_cpl_i = 1'b0;
    smp();
    chk("uf_err", cpl_err_o, 1);
    chk("uf_rd_ot", rd_ot_o, 0);
    chk("sb_empty", exp_q.size(), 0);

    // asynchronous reset while a command is presented
    cyc(); cmd_ready_i = 1'b0; rd_addr_i = 32'h300; rd_req_i = 1'b1;
    smp(); chk("rs_gnt", rd_gnt_o, 1);
    exp_q.push_back(exp_rd());
    cyc();
    smp(); chk("rs_valid", cmd_valid_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rs_valid0", cmd_valid_o, 0);
    chk("rs_gnt0", rd_gnt_o, 0);
    chk("rs_pend0", axi_pend_txn_o, 0);
    chk("rs_err0", cpl_err_o, 0);
    chk("rs_addr0", cmd_addr_o, 0);
    exp_q.delete();
    rd_req_i = 1'b0;
    cyc(); cyc(); rst = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
